// File: rtl/sync_fifo_bram36k.sv
`timescale 1ns/1ps
// sync_fifo_bram36k: single-clock first-word-fall-through FIFO on one 36 Kb
// block-RAM footprint, with full/empty, almost, watermark and sticky error
// status. Three fixed-geometry wrappers follow the core module.
//
// Read path: the RAM has a registered read. Its address is the post-edge read
// pointer, so the word latched at an edge is already the new head. A write into
// a location that becomes the head on the same edge bypasses the RAM, because a
// read-first RAM would return the stale word. DOUT selects between the RAM read
// register, the bypass register and zero. Zero is used only from a flush until
// the first write, so no pre-flush data can leak out.
module sync_fifo_bram36k #(
    parameter int DATA_WIDTH = 36,
    parameter int ADDR_WIDTH = 10,
    parameter int FULL_WM    = 3 * (2 ** ADDR_WIDTH) / 4,
    parameter int EMPTY_WM   = (2 ** ADDR_WIDTH) / 4
) (
    input  logic                  clock0,
    input  logic                  Async_Flush,
    input  logic [DATA_WIDTH-1:0] DIN,
    input  logic                  PUSH,
    input  logic                  POP,
    output logic [DATA_WIDTH-1:0] DOUT,
    output logic                  Full,
    output logic                  Empty,
    output logic                  Almost_Full,
    output logic                  Almost_Empty,
    output logic                  Full_Watermark,
    output logic                  Empty_Watermark,
    output logic                  Overrun_Error,
    output logic                  Underrun_Error
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    localparam logic [CW-1:0]         CNT_ZERO     = '0;
    localparam logic [CW-1:0]         CNT_ONE      = CW'(1);
    localparam logic [CW-1:0]         CNT_DEPTH    = CW'(DEPTH);
    localparam logic [CW-1:0]         CNT_DEPTH_M1 = CW'(DEPTH - 1);
    localparam logic [CW-1:0]         CNT_FULL_WM  = CW'(FULL_WM);
    localparam logic [CW-1:0]         CNT_EMPTY_WM = CW'(EMPTY_WM);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE      = ADDR_WIDTH'(1);

    // Where DOUT currently comes from.
    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_RAM  = 2'd1,
        SRC_BYP  = 2'd2
    } dout_src_e;

    // Storage and read-path registers. These are not reset: the source
    // selector decides whether their contents are visible.
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] ram_rd_q;
    logic [DATA_WIDTH-1:0] byp_data_q;
    logic [DATA_WIDTH-1:0] byp_data_d;

    // Pointers wrap modulo DEPTH. The separate count (one bit wider than a
    // pointer) tells full from empty when the two addresses are equal.
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q,  count_d;

    logic full_q,      full_d;
    logic empty_q,     empty_d;
    logic alm_full_q,  alm_full_d;
    logic alm_empty_q, alm_empty_d;
    logic full_wm_q,   full_wm_d;
    logic empty_wm_q,  empty_wm_d;
    logic overrun_q,   overrun_d;
    logic underrun_q,  underrun_d;

    dout_src_e src_q, src_d;

    logic push_ok;
    logic pop_ok;
    logic bypass;
    logic rd_en;

    // Each request is qualified only by the registered pre-edge Full/Empty.
    always_comb begin
        push_ok = PUSH & ~full_q;
        pop_ok  = POP  & ~empty_q;
    end

    // Advance the pointers and the occupancy count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Status flags are computed from the post-edge occupancy and then
    // registered. The error flags are sticky until a flush.
    always_comb begin
        full_d      = (count_d == CNT_DEPTH);
        empty_d     = (count_d == CNT_ZERO);
        alm_full_d  = (count_d == CNT_DEPTH_M1);
        alm_empty_d = (count_d == CNT_ONE);
        full_wm_d   = (count_d >= CNT_FULL_WM);
        empty_wm_d  = (count_d <= CNT_EMPTY_WM);
        overrun_d   = overrun_q  | (PUSH & full_q);
        underrun_d  = underrun_q | (POP  & empty_q);
    end

    // Output-source selection. The head is refreshed whenever the FIFO is
    // non-empty after the edge. A push landing on the new head address takes
    // the bypass path. When the FIFO is empty, everything holds, so DOUT keeps
    // its last value.
    always_comb begin
        rd_en      = (count_d != CNT_ZERO);
        bypass     = push_ok && (wr_ptr_q == rd_ptr_d);
        byp_data_d = byp_data_q;
        src_d      = src_q;
        if (bypass) begin
            byp_data_d = DIN;
        end
        if (rd_en) begin
            src_d = bypass ? SRC_BYP : SRC_RAM;
        end
    end

    // Block-RAM write port plus registered read of the post-edge head address.
    always_ff @(posedge clock0) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= DIN;
        end
        if (rd_en) begin
            ram_rd_q <= mem[rd_ptr_d];
        end
        byp_data_q <= byp_data_d;
    end

    // Control state, cleared immediately by Async_Flush.
    always_ff @(posedge clock0 or negedge Async_Flush) begin
        if (!Async_Flush) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            alm_full_q  <= 1'b0;
            alm_empty_q <= 1'b0;
            full_wm_q   <= 1'b0;
            empty_wm_q  <= 1'b1;
            overrun_q   <= 1'b0;
            underrun_q  <= 1'b0;
            src_q       <= SRC_ZERO;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            alm_full_q  <= alm_full_d;
            alm_empty_q <= alm_empty_d;
            full_wm_q   <= full_wm_d;
            empty_wm_q  <= empty_wm_d;
            overrun_q   <= overrun_d;
            underrun_q  <= underrun_d;
            src_q       <= src_d;
        end
    end

    // Head-of-FIFO data mux. It is driven only by registers.
    always_comb begin
        DOUT = '0;
        case (src_q)
            SRC_RAM: DOUT = ram_rd_q;
            SRC_BYP: DOUT = byp_data_q;
            default: DOUT = '0;
        endcase
    end

    assign Full            = full_q;
    assign Empty           = empty_q;
    assign Almost_Full     = alm_full_q;
    assign Almost_Empty    = alm_empty_q;
    assign Full_Watermark  = full_wm_q;
    assign Empty_Watermark = empty_wm_q;
    assign Overrun_Error   = overrun_q;
    assign Underrun_Error  = underrun_q;

endmodule

// 1024 x 36 configuration.
module f1024x36_1024x36 (
    input  logic        clock0,
    input  logic        Async_Flush,
    input  logic [35:0] DIN,
    input  logic        PUSH,
    input  logic        POP,
    output logic [35:0] DOUT,
    output logic        Full,
    output logic        Empty,
    output logic        Almost_Full,
    output logic        Almost_Empty,
    output logic        Full_Watermark,
    output logic        Empty_Watermark,
    output logic        Overrun_Error,
    output logic        Underrun_Error
);
    sync_fifo_bram36k #(.DATA_WIDTH(36), .ADDR_WIDTH(10)) u_fifo (
        .clock0(clock0), .Async_Flush(Async_Flush), .DIN(DIN), .PUSH(PUSH), .POP(POP),
        .DOUT(DOUT), .Full(Full), .Empty(Empty), .Almost_Full(Almost_Full),
        .Almost_Empty(Almost_Empty), .Full_Watermark(Full_Watermark),
        .Empty_Watermark(Empty_Watermark), .Overrun_Error(Overrun_Error),
        .Underrun_Error(Underrun_Error)
    );
endmodule

// 2048 x 18 configuration.
module f2048x18_2048x18 (
    input  logic        clock0,
    input  logic        Async_Flush,
    input  logic [17:0] DIN,
    input  logic        PUSH,
    input  logic        POP,
    output logic [17:0] DOUT,
    output logic        Full,
    output logic        Empty,
    output logic        Almost_Full,
    output logic        Almost_Empty,
    output logic        Full_Watermark,
    output logic        Empty_Watermark,
    output logic        Overrun_Error,
    output logic        Underrun_Error
);
    sync_fifo_bram36k #(.DATA_WIDTH(18), .ADDR_WIDTH(11)) u_fifo (
        .clock0(clock0), .Async_Flush(Async_Flush), .DIN(DIN), .PUSH(PUSH), .POP(POP),
        .DOUT(DOUT), .Full(Full), .Empty(Empty), .Almost_Full(Almost_Full),
        .Almost_Empty(Almost_Empty), .Full_Watermark(Full_Watermark),
        .Empty_Watermark(Empty_Watermark), .Overrun_Error(Overrun_Error),
        .Underrun_Error(Underrun_Error)
    );
endmodule

// 4096 x 9 configuration.
module f4096x9_4096x9 (
    input  logic       clock0,
    input  logic       Async_Flush,
    input  logic [8:0] DIN,
    input  logic       PUSH,
    input  logic       POP,
    output logic [8:0] DOUT,
    output logic       Full,
    output logic       Empty,
    output logic       Almost_Full,
    output logic       Almost_Empty,
    output logic       Full_Watermark,
    output logic       Empty_Watermark,
    output logic       Overrun_Error,
    output logic       Underrun_Error
);
    sync_fifo_bram36k #(.DATA_WIDTH(9), .ADDR_WIDTH(12)) u_fifo (
        .clock0(clock0), .Async_Flush(Async_Flush), .DIN(DIN), .PUSH(PUSH), .POP(POP),
        .DOUT(DOUT), .Full(Full), .Empty(Empty), .Almost_Full(Almost_Full),
        .Almost_Empty(Almost_Empty), .Full_Watermark(Full_Watermark),
        .Empty_Watermark(Empty_Watermark), .Overrun_Error(Overrun_Error),
        .Underrun_Error(Underrun_Error)
    );
endmodule

// File: tb/tb_sync_fifo_bram36k.sv
`timescale 1ns/1ps
// Scoreboard bench for sync_fifo_bram36k (1024 x 36). The driver pushes
// accepted words into a queue. A monitor checks the DUT on every falling edge:
// DOUT against the queue head, and every flag against the queue size.
module tb_sync_fifo_bram36k;

    localparam int DW       = 36;
    localparam int AW       = 10;
    localparam int DEPTH    = 1 << AW;
    localparam int FULL_WM  = 3 * DEPTH / 4;
    localparam int EMPTY_WM = DEPTH / 4;

    logic          clock0      = 1'b0;
    logic          Async_Flush = 1'b1;
    logic [DW-1:0] DIN         = '0;
    logic          PUSH        = 1'b0;
    logic          POP         = 1'b0;
    logic [DW-1:0] DOUT;
    logic Full, Empty, Almost_Full, Almost_Empty;
    logic Full_Watermark, Empty_Watermark, Overrun_Error, Underrun_Error;

    // Wrapper outputs: index 0 = 1024x36, 1 = 2048x18, 2 = 4096x9.
    logic [2:0]  w_full, w_empty, w_af, w_ae, w_fwm, w_ewm, w_ovr, w_unr;
    logic [35:0] w0_dout;
    logic [17:0] w1_dout;
    logic [8:0]  w2_dout;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [DW-1:0] sb[$];
    int            pops_pending = 0;
    logic          ovr_exp      = 1'b0;
    logic          unr_exp      = 1'b0;
    logic [DW-1:0] exp_dout     = '0;

    always #5 clock0 = ~clock0;

    sync_fifo_bram36k #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock0(clock0), .Async_Flush(Async_Flush), .DIN(DIN), .PUSH(PUSH), .POP(POP),
        .DOUT(DOUT), .Full(Full), .Empty(Empty), .Almost_Full(Almost_Full),
        .Almost_Empty(Almost_Empty), .Full_Watermark(Full_Watermark),
        .Empty_Watermark(Empty_Watermark), .Overrun_Error(Overrun_Error),
        .Underrun_Error(Underrun_Error)
    );

    f1024x36_1024x36 u_w0 (
        .clock0(clock0), .Async_Flush(Async_Flush), .DIN(36'd0), .PUSH(1'b0), .POP(1'b0),
        .DOUT(w0_dout), .Full(w_full[0]), .Empty(w_empty[0]), .Almost_Full(w_af[0]),
        .Almost_Empty(w_ae[0]), .Full_Watermark(w_fwm[0]), .Empty_Watermark(w_ewm[0]),
        .Overrun_Error(w_ovr[0]), .Underrun_Error(w_unr[0])
    );
    f2048x18_2048x18 u_w1 (
        .clock0(clock0), .Async_Flush(Async_Flush), .DIN(18'd0), .PUSH(1'b0), .POP(1'b0),
        .DOUT(w1_dout), .Full(w_full[1]), .Empty(w_empty[1]), .Almost_Full(w_af[1]),
        .Almost_Empty(w_ae[1]), .Full_Watermark(w_fwm[1]), .Empty_Watermark(w_ewm[1]),
        .Overrun_Error(w_ovr[1]), .Underrun_Error(w_unr[1])
    );
    f4096x9_4096x9 u_w2 (
        .clock0(clock0), .Async_Flush(Async_Flush), .DIN(9'd0), .PUSH(1'b0), .POP(1'b0),
        .DOUT(w2_dout), .Full(w_full[2]), .Empty(w_empty[2]), .Almost_Full(w_af[2]),
        .Almost_Empty(w_ae[2]), .Full_Watermark(w_fwm[2]), .Empty_Watermark(w_ewm[2]),
        .Overrun_Error(w_ovr[2]), .Underrun_Error(w_unr[2])
    );

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_word(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int k);
        logic [DW-1:0] kk;
        logic [DW-1:0] base;
        kk   = DW'(k);
        base = 36'h55000;
        return kk | (kk << 20) | base;
    endfunction

    function automatic logic [DW-1:0] rnd();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[DW-1:0];
    endfunction

    // One clock of stimulus. Acceptance follows the pre-edge occupancy of the
    // model; accepted pushes go into the scoreboard, and accepted pops are
    // handed to the monitor.
    task automatic cycle(input logic push, input logic pop, input logic [DW-1:0] din);
        int pre;
        @(negedge clock0);
        PUSH = push;
        POP  = pop;
        DIN  = din;
        @(posedge clock0);
        pre = sb.size();
        if (push && pre == DEPTH) ovr_exp = 1'b1;
        if (pop && pre == 0)      unr_exp = 1'b1;
        if (push && pre < DEPTH)  sb.push_back(din);
        if (pop && pre > 0)       pops_pending++;
    endtask

    // Assert the flush between clock edges, check the immediate effect,
    // hold it for hold_ns, then release it.
    task automatic flush_now(input int hold_ns);
        #2;
        PUSH        = 1'b0;
        POP         = 1'b0;
        Async_Flush = 1'b0;
        sb.delete();
        pops_pending = 0;
        ovr_exp      = 1'b0;
        unr_exp      = 1'b0;
        exp_dout     = '0;
        #1;
        check_bit("flush_empty", Empty, 1'b1);
        check_bit("flush_empty_wm", Empty_Watermark, 1'b1);
        check_bit("flush_full", Full, 1'b0);
        check_bit("flush_almost_full", Almost_Full, 1'b0);
        check_bit("flush_almost_empty", Almost_Empty, 1'b0);
        check_bit("flush_full_wm", Full_Watermark, 1'b0);
        check_bit("flush_overrun", Overrun_Error, 1'b0);
        check_bit("flush_underrun", Underrun_Error, 1'b0);
        check_word("flush_dout", DOUT, '0);
        #(hold_ns);
        Async_Flush = 1'b1;
    endtask

    // Monitor: retire consumed words, then compare DUT outputs to the model.
    initial begin : monitor
        logic [DW-1:0] gone;
        int occ;
        forever begin
            @(negedge clock0);
            if (pops_pending > 0) begin
                gone = sb.pop_front();
                pops_pending = 0;
            end
            occ = sb.size();
            if (occ > 0) exp_dout = sb[0];
            check_word("dout", DOUT, exp_dout);
            check_bit("empty", Empty, occ == 0);
            check_bit("full", Full, occ == DEPTH);
            check_bit("almost_full", Almost_Full, occ == DEPTH - 1);
            check_bit("almost_empty", Almost_Empty, occ == 1);
            check_bit("full_wm", Full_Watermark, occ >= FULL_WM);
            check_bit("empty_wm", Empty_Watermark, occ <= EMPTY_WM);
            check_bit("overrun", Overrun_Error, ovr_exp);
            check_bit("underrun", Underrun_Error, unr_exp);
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        flush_now(40);
        for (int i = 0; i < 3; i++) begin
            check_bit("wrap_empty", w_empty[i], 1'b1);
            check_bit("wrap_empty_wm", w_ewm[i], 1'b1);
            check_bit("wrap_full", w_full[i], 1'b0);
            check_bit("wrap_errors", w_ovr[i] | w_unr[i] | w_af[i] | w_ae[i] | w_fwm[i], 1'b0);
        end
        check_word("wrap_dout", {w0_dout[8:0], w1_dout[8:0], w2_dout}, '0);

        // Fill with the patterned words, then one push while full.
        for (int k = 0; k < DEPTH; k++) cycle(1'b1, 1'b0, pat(k));
        cycle(1'b1, 1'b0, 36'hF_FFFF_FFFF);
        // Drain in order, then one pop while empty.
        for (int k = 0; k < DEPTH; k++) cycle(1'b0, 1'b1, '0);
        cycle(1'b0, 1'b1, '0);
        cycle(1'b0, 1'b0, '0);
        // Pointers must be untouched by the rejected pop.
        cycle(1'b1, 1'b0, 36'hA5);
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, '0);
        cycle(1'b0, 1'b0, '0);

        // Half fill, then steady simultaneous push/pop across several wraps.
        for (int k = 0; k < DEPTH / 2; k++) cycle(1'b1, 1'b0, rnd());
        for (int k = 0; k < 3 * DEPTH; k++) cycle(1'b1, 1'b1, rnd());

        // Biased random phases that reach full and then empty.
        for (int k = 0; k < 2200; k++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, rnd());
        for (int k = 0; k < 2200; k++)
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, rnd());
        for (int k = 0; k < 300; k++)
            cycle($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, rnd());

        // Flush in the middle of traffic, then keep going from a clean state.
        flush_now(40);
        for (int k = 0; k < 200; k++)
            cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, rnd());

        @(negedge clock0);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo_bram36k.md
Name: sync_fifo_bram36k

Overview:
- Single-clock, first-word-fall-through (FWFT) FIFO built on one 36 Kb block-RAM footprint.
- Three top-level configurations are thin wrappers that fix the parameters:
  - f1024x36_1024x36: DATA_WIDTH=36, ADDR_WIDTH=10
  - f2048x18_2048x18: DATA_WIDTH=18, ADDR_WIDTH=11
  - f4096x9_4096x9: DATA_WIDTH=9, ADDR_WIDTH=12
- Provides full/empty, almost, watermark and error status to the surrounding datapath.

Parameters:
- DATA_WIDTH, 36, width of DIN and DOUT; write and read widths are identical.
- ADDR_WIDTH, 10, log2 of depth; DEPTH = 2**ADDR_WIDTH entries, all usable.
- FULL_WM, 3*DEPTH/4, occupancy at or above which Full_Watermark asserts.
- EMPTY_WM, DEPTH/4, occupancy at or below which Empty_Watermark asserts.

Ports:
- clock0  in  1  sole clock; all state updates on the rising edge.
- Async_Flush  in  1  asynchronous active-low reset/flush. 0 clears the FIFO immediately; 1 = normal operation.
- DIN  in  DATA_WIDTH  write data.
- PUSH  in  1  write request, sampled at rising edge.
- POP  in  1  read request, sampled at rising edge.
- DOUT  out  DATA_WIDTH  head-of-FIFO data (FWFT).
- Full  out  1  occupancy == DEPTH.
- Empty  out  1  occupancy == 0.
- Almost_Full  out  1  occupancy == DEPTH-1.
- Almost_Empty  out  1  occupancy == 1.
- Full_Watermark  out  1  occupancy >= FULL_WM.
- Empty_Watermark  out  1  occupancy <= EMPTY_WM.
- Overrun_Error  out  1  sticky: a PUSH occurred while Full.
- Underrun_Error  out  1  sticky: a POP occurred while Empty.

Behaviour:
- Reset (Async_Flush=0, asynchronous, any time including mid-operation):
  - Pointers and count = 0.
  - DOUT = 0, Empty = 1, Empty_Watermark = 1.
  - Full, Almost_Full, Almost_Empty, Full_Watermark, Overrun_Error, Underrun_Error = 0.
  - Memory contents are don't-care; no old data may appear after the flush.
- Write:
  - On a rising edge with PUSH=1 and Full=0 (pre-edge state), DIN is stored at the write pointer.
  - Write pointer increments, wrapping modulo DEPTH.
- Read:
  - On a rising edge with POP=1 and Empty=0, the head entry is consumed and the read pointer increments modulo DEPTH.
  - Within the same clock cycle (registered output, settled well before the next edge), DOUT shows the new head entry.
- FWFT:
  - When non-empty, DOUT always holds the oldest unread entry without any POP.
  - After a write into an empty FIFO, Empty deasserts and DOUT is valid no later than the second rising edge after the write edge.
  - When empty, DOUT holds its last value.
- Simultaneous PUSH and POP:
  - Each is qualified independently on pre-edge Full/Empty.
  - If both are accepted, occupancy is unchanged.
  - PUSH while Full is dropped even if POP is also active.
  - POP while Empty is ignored even if PUSH is also active.
- Status flags:
  - Occupancy is an (ADDR_WIDTH+1)-bit count.
  - All flags are registered and reflect post-edge occupancy.
  - No combinational path from PUSH/POP to any output.
- Errors:
  - PUSH=1 while Full sets Overrun_Error; POP=1 while Empty sets Underrun_Error.
  - Both stay set until Async_Flush.
  - The offending operation has no effect on data or pointers.
- Wrap-around: pointers carry an extra MSB (or an equivalent count) so full and empty are distinguishable at identical addresses.

Test Plan:
- Flush then idle: hold Async_Flush=0 for 40 ns, release -> Empty=1, Empty_Watermark=1, all other flags 0, DOUT=0.
- Fill: push DEPTH words, word k = (k | k<<20 | 0x55000) truncated to DATA_WIDTH. Required response:
  - Empty drops after the first push.
  - Almost_Empty is high at occupancy 1.
  - Full_Watermark is high from occupancy FULL_WM.
  - Almost_Full is high at DEPTH-1.
  - Full is high after word DEPTH-1.
- Drain FWFT: before the first pop, DOUT = word 0. After the k-th pop edge, DOUT = word k for k=1..DEPTH-1; the last pop sets Empty=1, and Empty_Watermark is asserted from occupancy EMPTY_WM down.
- Overrun: push once more while Full -> data unchanged, Overrun_Error=1 and stays 1 until flush.
- Underrun: pop while Empty -> Underrun_Error=1, pointers unchanged; a later push of 0xA5 yields DOUT=0xA5.
- Wrap and concurrency:
  - Run 3*DEPTH words with simultaneous push/pop at half occupancy: occupancy stays constant and output order matches input order.
  - Assert Async_Flush mid-stream: all flags return to their reset values immediately.
